// File: rtl/contra_screen_pkg.sv
// Shared types and constants for the screen sequencer: FSM states, brightness range,
// frame-tick scan position, layer ids and the per-channel brightness scaler.
package contra_screen_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OUT_SPL  = 3'd1,
        IN_SPL   = 3'd2,
        HOLD     = 3'd3,
        OUT_GAME = 3'd4,
        IN_GAME  = 3'd5
    } state_t;

    localparam logic [4:0] BRIGHT_MAX   = 5'd16;
    localparam logic [9:0] FRAME_TICK_X = 10'd0;
    localparam logic [9:0] FRAME_TICK_Y = 10'd480;
    localparam logic [1:0] LAYER_GAME   = 2'd0;

    // (c * b) >> 4 on a 9-bit product; b never exceeds 16 so bit 8 stays clear.
    function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] b);
        logic [8:0] prod;
        prod = {5'd0, c} * {4'd0, b};
        return prod[8] ? 4'hF : prod[7:4];
    endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Control port of the screen sequencer. start is a one-cycle request accepted only while
// busy=0 and screen_id!=0; busy rises the cycle after acceptance; done pulses as busy falls.
interface screen_sequencer_if;
    logic       start;
    logic [1:0] screen_id;
    logic       skip;
    logic       busy;
    logic       done;

    modport master (output start, screen_id, skip, input busy, done);
    modport slave  (input start, screen_id, skip, output busy, done);
endinterface

// File: rtl/frame_tick_gen.sv
// One-cycle frame pulse, registered, on the rising edge of "scan position == (0,480)".
module frame_tick_gen
    import contra_screen_pkg::*;
(
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       frame_tick
);
    logic at_pos;
    logic at_pos_q;

    assign at_pos = (DrawX == FRAME_TICK_X) && (DrawY == FRAME_TICK_Y);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            at_pos_q   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            at_pos_q   <= at_pos;
            frame_tick <= at_pos && !at_pos_q;
        end
    end
endmodule

// File: rtl/screen_sequencer.sv
// Splash/game layer sequencer on the VGA pixel path. Define SCREEN_SEQ_FADE_EN for
// brightness fades around each swap; otherwise layers swap on frame ticks at full brightness.
module screen_sequencer
    import contra_screen_pkg::*;
#(
    parameter int HOLD_FRAMES      = 120,
    parameter int FADE_STEP_FRAMES = 4
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    screen_sequencer_if.slave ctrl,
    input  logic [3:0]        game_red,
    input  logic [3:0]        game_green,
    input  logic [3:0]        game_blue,
    input  logic [3:0]        splash_red,
    input  logic [3:0]        splash_green,
    input  logic [3:0]        splash_blue,
    output logic [1:0]        layer_sel,
    output logic [4:0]        brightness,
    output logic              frame_tick,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output state_t            state_dbg
);
    // Fade steps and hold frames never overlap, so one frame counter serves both.
    localparam int CNT_MAX = (HOLD_FRAMES > FADE_STEP_FRAMES) ? HOLD_FRAMES : FADE_STEP_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES);
`ifdef SCREEN_SEQ_FADE_EN
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(FADE_STEP_FRAMES - 1);
`endif

    state_t           state;
    logic [1:0]       id_q;
    logic             skip_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             hold_exit;
    logic [3:0]       src_r, src_g, src_b;

    frame_tick_gen u_frame_tick (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .frame_tick (frame_tick)
    );

    assign cnt_inc   = cnt + CNT_W'(1);
    assign hold_exit = frame_tick && (skip_q || ctrl.skip || (cnt_inc >= HOLD_LAST));
    assign state_dbg = state;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            layer_sel  <= LAYER_GAME;
            brightness <= BRIGHT_MAX;
            ctrl.busy  <= 1'b0;
            ctrl.done  <= 1'b0;
            id_q       <= 2'd0;
            skip_q     <= 1'b0;
            cnt        <= '0;
        end else begin
            ctrl.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl.start && (ctrl.screen_id != 2'd0)) begin
                        id_q      <= ctrl.screen_id;
                        ctrl.busy <= 1'b1;
                        cnt       <= '0;
                        state     <= OUT_SPL;
                    end
                end
`ifdef SCREEN_SEQ_FADE_EN
                OUT_SPL, OUT_GAME: begin
                    if (frame_tick) begin
                        if (brightness == 5'd0) begin
                            layer_sel <= (state == OUT_SPL) ? id_q : LAYER_GAME;
                            state     <= (state == OUT_SPL) ? IN_SPL : IN_GAME;
                            cnt       <= '0;
                        end else if (cnt == STEP_LAST) begin
                            cnt        <= '0;
                            brightness <= brightness - 5'd1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                IN_SPL, IN_GAME: begin
                    if (brightness == BRIGHT_MAX) begin
                        cnt    <= '0;
                        skip_q <= 1'b0;
                        if (state == IN_SPL) begin
                            state <= HOLD;
                        end else begin
                            state     <= IDLE;
                            ctrl.busy <= 1'b0;
                            ctrl.done <= 1'b1;
                        end
                    end else if (frame_tick) begin
                        if (cnt == STEP_LAST) begin
                            cnt        <= '0;
                            brightness <= brightness + 5'd1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                HOLD: begin
                    if (ctrl.skip) skip_q <= 1'b1;
                    if (hold_exit) begin
                        state  <= OUT_GAME;
                        cnt    <= '0;
                        skip_q <= 1'b0;
                    end else if (frame_tick) begin
                        cnt <= cnt_inc;
                    end
                end
`else
                // OUT_SPL only waits for the frame tick that carries the swap.
                OUT_SPL: begin
                    if (frame_tick) begin
                        layer_sel <= id_q;
                        state     <= HOLD;
                        cnt       <= '0;
                        skip_q    <= 1'b0;
                    end
                end
                HOLD: begin
                    if (ctrl.skip) skip_q <= 1'b1;
                    if (hold_exit) begin
                        layer_sel <= LAYER_GAME;
                        state     <= IDLE;
                        ctrl.busy <= 1'b0;
                        ctrl.done <= 1'b1;
                        cnt       <= '0;
                        skip_q    <= 1'b0;
                    end else if (frame_tick) begin
                        cnt <= cnt_inc;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        src_r = game_red;
        src_g = game_green;
        src_b = game_blue;
        if (layer_sel != LAYER_GAME) begin
            src_r = splash_red;
            src_g = splash_green;
            src_b = splash_blue;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            {red, green, blue} <= '0;
        end else if (!blank) begin
            {red, green, blue} <= '0;
        end else begin
`ifdef SCREEN_SEQ_FADE_EN
            red   <= scale(src_r, brightness);
            green <= scale(src_g, brightness);
            blue  <= scale(src_b, brightness);
`else
            red   <= src_r;
            green <= src_g;
            blue  <= src_b;
`endif
        end
    end
endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer with HOLD_FRAMES=3, FADE_STEP_FRAMES=1; follows the same
// SCREEN_SEQ_FADE_EN setting as the design.
`timescale 1ns/1ps
module tb_screen_sequencer;
  import contra_screen_pkg::*;

  localparam int HOLD_N = 3;
  localparam int STEP_N = 1;

  logic       vga_clk = 1'b0;
  logic       reset;
  logic [9:0] DrawX, DrawY;
  logic       blank;
  logic [3:0] game_red, game_green, game_blue;
  logic [3:0] splash_red, splash_green, splash_blue;
  logic [1:0] layer_sel;
  logic [4:0] brightness;
  logic       frame_tick;
  logic [3:0] red, green, blue;
  state_t     state_dbg;

  screen_sequencer_if ctrl();

  screen_sequencer #(.HOLD_FRAMES(HOLD_N), .FADE_STEP_FRAMES(STEP_N)) dut (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .blank        (blank),
    .ctrl         (ctrl),
    .game_red     (game_red),
    .game_green   (game_green),
    .game_blue    (game_blue),
    .splash_red   (splash_red),
    .splash_green (splash_green),
    .splash_blue  (splash_blue),
    .layer_sel    (layer_sel),
    .brightness   (brightness),
    .frame_tick   (frame_tick),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .state_dbg    (state_dbg)
  );

  // clock / watchdog
  always #5 vga_clk = ~vga_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded 500000 ns, required completion earlier");
    $fatal(1, "watchdog");
  end

  // scoreboard state: expected {state, layer_sel, brightness, busy} after each frame tick
  int n_checks  = 0;
  int n_pass    = 0;
  int done_seen = 0;
  int done_exp  = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // driver tasks
  task automatic frame(input int hold_cyc);
    @(posedge vga_clk); #1;
    DrawX = 10'd0;
    DrawY = 10'd480;
    repeat (hold_cyc) @(posedge vga_clk);
    #1;
    DrawX = 10'd7;
    DrawY = 10'd100;
    repeat (2) @(posedge vga_clk);
  endtask

  task automatic tick_exp(input state_t s, input logic [1:0] l, input logic [4:0] b, input logic bz);
    exp_q.push_back({s, l, b, bz});
    frame(1);
  endtask

  task automatic pulse_start(input logic [1:0] id);
    @(posedge vga_clk); #1;
    ctrl.start     = 1'b1;
    ctrl.screen_id = id;
    @(posedge vga_clk); #1;
    ctrl.start     = 1'b0;
  endtask

  task automatic pulse_skip();
    @(posedge vga_clk); #1 ctrl.skip = 1'b1;
    @(posedge vga_clk); #1 ctrl.skip = 1'b0;
  endtask

  task automatic colour_check(input string nm, input logic [11:0] exp_on);
    @(negedge vga_clk);
    check({nm, "_rgb"}, 32'({red, green, blue}), 32'(exp_on));
    @(posedge vga_clk); #1 blank = 1'b0;
    @(posedge vga_clk);
    @(negedge vga_clk);
    check({nm, "_blank_rgb"}, 32'({red, green, blue}), 32'h0);
    @(posedge vga_clk); #1 blank = 1'b1;
  endtask

  task automatic ramp_down(input state_t s, input logic [1:0] l);
    for (int i = 1; i <= 16; i++) tick_exp(s, l, 5'(16 - i), 1'b1);
  endtask

  task automatic ramp_up(input state_t s, input logic [1:0] l);
    for (int i = 1; i <= 16; i++) tick_exp(s, l, 5'(i), 1'b1);
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, "_state"},  32'(state_dbg), 32'(IDLE));
    check({nm, "_layer"},  32'(layer_sel), 32'd0);
    check({nm, "_bright"}, 32'(brightness), 32'd16);
    check({nm, "_busy"},   32'(ctrl.busy), 32'd0);
    check({nm, "_rgb"},    32'({red, green, blue}), 32'h0);
  endtask

  // tick monitor: compares the registered state one cycle after every frame_tick
  initial begin
    logic [10:0] e;
    logic [10:0] a;
    forever begin
      @(negedge vga_clk);
      if (frame_tick === 1'b1) begin
        @(negedge vga_clk);
        a = {state_dbg, layer_sel, brightness, ctrl.busy};
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_tick: got state=%0d layer=%0d bright=%0d busy=%0d, required no tick",
                   a[10:8], a[7:6], a[5:1], a[0]);
        end else begin
          e = exp_q.pop_front();
          if (a === e) n_pass++;
          else $display("FAIL tick_snapshot: got state=%0d layer=%0d bright=%0d busy=%0d, required state=%0d layer=%0d bright=%0d busy=%0d",
                        a[10:8], a[7:6], a[5:1], a[0], e[10:8], e[7:6], e[5:1], e[0]);
        end
      end
    end
  end

  // done monitor: every done pulse must coincide with busy low
  initial begin
    forever begin
      @(negedge vga_clk);
      if (ctrl.done === 1'b1) begin
        done_seen++;
        check("done_with_busy_low", 32'(ctrl.busy), 32'd0);
      end
    end
  end

  // stimulus
  initial begin
    reset = 1'b1;
    DrawX = 10'd7;  DrawY = 10'd100;  blank = 1'b1;
    game_red = 4'hF;   game_green = 4'h8;   game_blue = 4'h1;
    splash_red = 4'hA; splash_green = 4'h5; splash_blue = 4'h3;
    ctrl.start = 1'b0; ctrl.screen_id = 2'd0; ctrl.skip = 1'b0;
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    check_reset_values("reset");
    check("reset_done", 32'(ctrl.done), 32'd0);
    check("reset_tick", 32'(frame_tick), 32'd0);
    @(posedge vga_clk); #1 reset = 1'b0;

    // coordinates held at (0,480) for three cycles give a single tick
    tick_exp_hold: begin
      exp_q.push_back({IDLE, 2'd0, 5'd16, 1'b0});
      frame(3);
    end
    pulse_skip();
    tick_exp(IDLE, 2'd0, 5'd16, 1'b0);
    pulse_start(2'd0);
    @(negedge vga_clk);
    check("start_id0_state", 32'(state_dbg), 32'(IDLE));
    check("start_id0_busy", 32'(ctrl.busy), 32'd0);
    tick_exp(IDLE, 2'd0, 5'd16, 1'b0);
    colour_check("idle_game", 12'hF81);

`ifdef SCREEN_SEQ_FADE_EN
    // full sequence, screen 2, with ignored skip/start during the fade-out
    pulse_start(2'd2);
    @(negedge vga_clk);
    check("seq1_busy", 32'(ctrl.busy), 32'd1);
    check("seq1_state", 32'(state_dbg), 32'(OUT_SPL));
    for (int i = 1; i <= 16; i++) begin
      tick_exp(OUT_SPL, 2'd0, 5'(16 - i), 1'b1);
      if (i == 4) pulse_skip();
      if (i == 5) begin
        pulse_start(2'd3);
        @(negedge vga_clk);
        check("start_while_busy_state", 32'(state_dbg), 32'(OUT_SPL));
      end
      if (i == 8) colour_check("game_half", 12'h740);
    end
    tick_exp(IN_SPL, 2'd2, 5'd0, 1'b1);
    ramp_up(IN_SPL, 2'd2);
    colour_check("splash_full", 12'hA53);
    tick_exp(HOLD, 2'd2, 5'd16, 1'b1);
    tick_exp(HOLD, 2'd2, 5'd16, 1'b1);
    tick_exp(OUT_GAME, 2'd2, 5'd16, 1'b1);
    ramp_down(OUT_GAME, 2'd2);
    tick_exp(IN_GAME, 2'd0, 5'd0, 1'b1);
    done_exp++;
    ramp_up(IN_GAME, 2'd0);

    // skip in the first hold frame
    pulse_start(2'd1);
    ramp_down(OUT_SPL, 2'd0);
    tick_exp(IN_SPL, 2'd1, 5'd0, 1'b1);
    ramp_up(IN_SPL, 2'd1);
    @(negedge vga_clk);
    check("seq2_in_hold", 32'(state_dbg), 32'(HOLD));
    pulse_skip();
    tick_exp(OUT_GAME, 2'd1, 5'd16, 1'b1);
    ramp_down(OUT_GAME, 2'd1);
    tick_exp(IN_GAME, 2'd0, 5'd0, 1'b1);
    done_exp++;
    ramp_up(IN_GAME, 2'd0);

    // reset mid-hold
    pulse_start(2'd2);
    ramp_down(OUT_SPL, 2'd0);
    tick_exp(IN_SPL, 2'd2, 5'd0, 1'b1);
    ramp_up(IN_SPL, 2'd2);
    tick_exp(HOLD, 2'd2, 5'd16, 1'b1);
`else
    // swap-only sequence, screen 3
    pulse_start(2'd3);
    @(negedge vga_clk);
    check("seq1_busy", 32'(ctrl.busy), 32'd1);
    check("seq1_state", 32'(state_dbg), 32'(OUT_SPL));
    pulse_start(2'd1);
    @(negedge vga_clk);
    check("start_while_busy_state", 32'(state_dbg), 32'(OUT_SPL));
    tick_exp(HOLD, 2'd3, 5'd16, 1'b1);
    colour_check("splash_full", 12'hA53);
    tick_exp(HOLD, 2'd3, 5'd16, 1'b1);
    tick_exp(HOLD, 2'd3, 5'd16, 1'b1);
    done_exp++;
    tick_exp(IDLE, 2'd0, 5'd16, 1'b0);

    // skip in the first hold frame
    pulse_start(2'd1);
    tick_exp(HOLD, 2'd1, 5'd16, 1'b1);
    pulse_skip();
    done_exp++;
    tick_exp(IDLE, 2'd0, 5'd16, 1'b0);

    // reset mid-hold
    pulse_start(2'd2);
    tick_exp(HOLD, 2'd2, 5'd16, 1'b1);
`endif
    @(negedge vga_clk);
    check("pre_reset_layer", 32'(layer_sel), 32'd2);
    pulse_skip();
    @(posedge vga_clk); #1 reset = 1'b1;
    @(negedge vga_clk);
    check_reset_values("mid_reset");
    @(posedge vga_clk); #1 reset = 1'b0;
    tick_exp(IDLE, 2'd0, 5'd16, 1'b0);
    tick_exp(IDLE, 2'd0, 5'd16, 1'b0);

    repeat (6) @(posedge vga_clk);
    @(negedge vga_clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(done_seen), 32'(done_exp));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/screen_sequencer.md
# screen_sequencer

Sequences full-screen splash layers (title, stage card, game over) against the live game layer on the VGA pixel path. Counts frames from the DrawX/DrawY scan position, runs a fade-out → layer swap → fade-in → hold → fade-out → swap back → fade-in sequence, and applies the resulting brightness to the selected layer's colour. Sits between the per-layer mappers (ROM + palette stages) and the VGA output pins.

## Interface
- HOLD_FRAMES, 120: frames the splash is held at full brightness.
- FADE_STEP_FRAMES, 4: frames per brightness step (≥1).
- vga_clk  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high.
- DrawX, DrawY  in  10 each  current scan position.
- blank  in  1  1 = active video; 0 forces output colour to 0.
- start  in  1  single-cycle request to show a splash.
- screen_id  in  2  splash to show (1..3); 0 = invalid, start ignored.
- skip  in  1  ends HOLD early.
- game_red/green/blue  in  4 each  game-layer colour.
- splash_red/green/blue  in  4 each  splash colour, addressed by layer_sel.
- layer_sel  out  2  0 = game, 1..3 = splash index.
- brightness  out  5  0..16.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on return to IDLE.
- frame_tick  out  1  one-cycle pulse per frame.
- red, green, blue  out  4 each  final colour, registered.

## Operation
- frame_tick: asserted the cycle after sampled (DrawX,DrawY) becomes (0,480); edge-detected against the previous sample, so it fires once per frame even if coordinates hold.
- States: IDLE, OUT_SPL, IN_SPL, HOLD, OUT_GAME, IN_GAME.
- IDLE: layer_sel=0, brightness=16, busy=0. start with screen_id≠0 latches screen_id, sets busy=1 next cycle, and enters OUT_SPL.
- Fade states: the step counter advances on frame_tick. Every FADE_STEP_FRAMES ticks, brightness changes by ±1: OUT_* decrements, IN_* increments.
- OUT_SPL at brightness 0, on the next frame_tick: layer_sel ← latched id, then IN_SPL.
- IN_SPL at 16 → HOLD; hold counter cleared.
- HOLD: counts frame_ticks. Leaves for OUT_GAME at the tick where the count reaches HOLD_FRAMES, or at the next tick after skip was seen (skip latched). HOLD_FRAMES=0 leaves at the first tick.
- OUT_GAME at 0, on the next frame_tick: layer_sel ← 0, then IN_GAME.
- IN_GAME at 16 → IDLE with done=1 for one cycle and busy=0.
- Layer swaps occur only on frame_tick at brightness 0, so no mid-frame tearing.
- start while busy: ignored. skip outside HOLD: ignored, not latched.
- Colour: src = layer_sel==0 ? game : splash. Output = blank ? (src·brightness)>>4 : 0, per channel. Product is 9 bits. brightness 16 is identity; 0 is black.

## Timing
- Reset values: state IDLE, layer_sel 0, brightness 16, busy 0, done 0, frame_tick 0, red/green/blue 0, all counters 0.
- Colour path latency: 1 vga_clk from DrawX/DrawY/blank/colour inputs to red/green/blue.
- Full sequence length with fade: 4·16·FADE_STEP_FRAMES + HOLD_FRAMES + 2 swap ticks frames, ±1 frame of start alignment.
- Reset asserted mid-sequence: immediate return to reset values. Any latched id or skip is discarded.

## Configuration
- SCREEN_SEQ_FADE_EN defined: fade behaviour as above.
- SCREEN_SEQ_FADE_EN undefined: brightness is constant 16 and fade states are removed.
  - start → at the next frame_tick, layer_sel ← id and enter HOLD.
  - HOLD exit → at the next frame_tick, layer_sel ← 0 and enter IDLE with done.
  - The multiplier is removed; output = blank ? src : 0.

## Structure
- Package contra_screen_pkg holds:
  - state enum;
  - BRIGHT_MAX=16;
  - FRAME_TICK_X=0, FRAME_TICK_Y=480;
  - layer id constants (LAYER_GAME=0).
- Sub-module frame_tick_gen: DrawX/DrawY compare plus edge detect, producing frame_tick.

## Test plan
Benches use HOLD_FRAMES=3 and FADE_STEP_FRAMES=1 unless noted.
- Reset mid-HOLD (layer_sel=2) → next cycle layer_sel=0, brightness=16, busy=0, red/green/blue=0.
- start, screen_id=2 → brightness 16→0 over 16 ticks. layer_sel becomes 2 on tick 17. brightness reaches 16 on tick 33, then 3 hold ticks, then a symmetric return. done pulses once and busy falls in the same cycle.
- skip pulsed in the first HOLD frame → OUT_GAME entered at the next frame_tick. skip pulsed in IDLE → no effect.
- start with screen_id=0, and start while busy → state unchanged, no done.
- Colour check: game=(F,8,1), brightness=8, blank=1 → output (7,4,0) one cycle later. Same inputs with blank=0 → (0,0,0).
- SCREEN_SEQ_FADE_EN undefined → brightness stays 16 throughout. layer_sel=3 from the first frame_tick after start, 0 after 3 further ticks, then done.
